// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller: latches operands on start, then
// produces one quotient bit per clock and reports busy, done and divide-by-zero.
module div_seq_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH+1:0] t_s;
  logic             borrow_s;
  logic [WIDTH:0]   r_next_s;
  logic [WIDTH-1:0] q_next_s;

  // One restoring iteration; r_r stays below the divisor, so {r_r, msb} equals the shifted remainder.
  always_comb begin
    t_s      = {r_r, q_r[WIDTH-1]} - {2'b00, d_r};
    borrow_s = t_s[WIDTH+1];
    if (borrow_s) begin
      r_next_s = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
    end else begin
      r_next_s = t_s[WIDTH:0];
    end
    q_next_s = {q_r[WIDTH-2:0], ~borrow_s};
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_r         <= '0;
              q_r         <= dividend;
              d_r         <= divisor;
              cnt_r       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_r     <= RUN;
            end else begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          r_r   <= r_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - CW'(1);
          // Results come from this edge's iteration, not the stale registers.
          if (cnt_r == CW'(1)) begin
            quotient  <= q_next_s;
            remainder <= r_next_s[WIDTH-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
